// File: rtl/render_sched_pkg.sv
// Purpose: shared types and constants for the render frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package render_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SYNC = 3'd1,
        ST_START     = 3'd2,
        ST_RENDER    = 3'd3,
        ST_SWAP      = 3'd4
    } sched_state_t;

    // A pose is nine signed Q16.16 components packed as
    // {ori xyz, forward xyz, up xyz}, ori x in the most significant slot.
    localparam int POSE_COMPONENTS = 9;
    localparam int POSE_AXES       = 3;

    // Group index of each vector inside the packed pose.
    localparam int POSE_IDX_UP  = 0;
    localparam int POSE_IDX_FWD = 1;
    localparam int POSE_IDX_ORI = 2;

    // Dropped-strobe counter saturation value.
    localparam logic [7:0] DROP_MAX = 8'hFF;

    // LSB of one component in the packed pose.
    // group: POSE_IDX_*, axis: 0 = x, 1 = y, 2 = z (x sits highest in its group).
    function automatic int pose_comp_lsb(input int group, input int axis, input int w);
        return (group * POSE_AXES + (POSE_AXES - 1 - axis)) * w;
    endfunction

endpackage

// File: rtl/render_watchdog.sv
// Purpose: frame watchdog, counts RENDER cycles and flags expiry at TIMEOUT_CYCLES-1.
// Latency: count registered; expire is a decode of the current count (same cycle).
// Backpressure: none; holds at the last value once expired until cleared.
// Ports: clk/rst_n (async active-low), clear (zero count), enable (count up),
//        expire (count == TIMEOUT_CYCLES-1).
module render_watchdog #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Clear has priority so a START cycle always restarts from zero.
    // The count parks at LAST so a stalled scheduler never wraps into a
    // false "fresh" window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/render_frame_scheduler.sv
// Purpose: sequences lockstep renderers per frame: vsync-gated start, shared pose latch,
//          done collection, display buffer flip, dropped-strobe and hung-frame flags.
// Latency: strobe at n -> start_out/pose_out at n+1; last done at m -> SWAP at m+1,
//          buffer_sel_out/frame_count_out at m+2. All outputs registered.
// Backpressure: none; strobes arriving while busy are counted as dropped, never queued.
// Ports: clk_in/rst_in (async active-low), enable_in, new_frame_in, done_in[NUM_RENDERERS],
//        pose_in -> start_out, pose_out, buffer_sel_out, busy_out, frame_count_out,
//        dropped_count_out, timeout_out.
module render_frame_scheduler
    import render_sched_pkg::*;
#(
    parameter int NUM_RENDERERS  = 2,
    parameter int POSE_W         = 32,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int VSYNC_LOCK     = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              enable_in,
    input  logic                              new_frame_in,
    input  logic [NUM_RENDERERS-1:0]          done_in,
    input  logic [POSE_COMPONENTS*POSE_W-1:0] pose_in,
    output logic                              start_out,
    output logic [POSE_COMPONENTS*POSE_W-1:0] pose_out,
    output logic                              buffer_sel_out,
    output logic                              busy_out,
    output logic [15:0]                       frame_count_out,
    output logic [7:0]                        dropped_count_out,
    output logic                              timeout_out
);

    localparam bit FREE_RUN = (VSYNC_LOCK == 0);

    sched_state_t              state;
    logic [NUM_RENDERERS-1:0]  done_seen;
    logic [NUM_RENDERERS-1:0]  done_next;
    logic                      all_done;
    logic                      wd_clear;
    logic                      wd_enable;
    logic                      wd_expire;
    logic                      in_frame;

    // Done flags accumulate so pulses are captured and levels simply hold.
    assign done_next = done_seen | done_in;
    assign all_done  = &done_next;

    // Watchdog is zeroed in START and advances once per RENDER cycle.
    assign wd_clear  = (state == ST_START);
    assign wd_enable = (state == ST_RENDER);

    // Strobes arriving here cannot start a frame and are counted as dropped.
    assign in_frame = (state == ST_START) || (state == ST_RENDER) || (state == ST_SWAP);

    render_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // Scheduler FSM. Outputs are assigned on the transition edge so that
    // they are valid during the state they describe (start_out in START,
    // busy_out over START..RENDER).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_IDLE;
            done_seen       <= '0;
            start_out       <= 1'b0;
            pose_out        <= '0;
            buffer_sel_out  <= 1'b0;
            busy_out        <= 1'b0;
            frame_count_out <= '0;
            timeout_out     <= 1'b0;
        end else begin
            start_out <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (enable_in) begin
                        state <= ST_WAIT_SYNC;
                    end
                end

                ST_WAIT_SYNC: begin
                    // Dropping enable while waiting parks immediately; no frame is in flight.
                    if (!enable_in) begin
                        state <= ST_IDLE;
                    end else if (FREE_RUN || new_frame_in) begin
                        state     <= ST_START;
                        start_out <= 1'b1;
                        busy_out  <= 1'b1;
                        pose_out  <= pose_in;
                    end
                end

                ST_START: begin
                    // done_in is deliberately not sampled here: a level still
                    // high from the previous frame must not complete this one.
                    state     <= ST_RENDER;
                    done_seen <= '0;
                end

                ST_RENDER: begin
                    done_seen <= done_next;
                    // Completion is tested before the watchdog so a frame that
                    // finishes on the expiry cycle still counts.
                    if (all_done) begin
                        state    <= ST_SWAP;
                        busy_out <= 1'b0;
                    end else if (wd_expire) begin
                        state       <= ST_WAIT_SYNC;
                        busy_out    <= 1'b0;
                        timeout_out <= 1'b1;
                    end
                end

                ST_SWAP: begin
                    buffer_sel_out  <= ~buffer_sel_out;
                    frame_count_out <= frame_count_out + 16'd1;
                    if (!enable_in) begin
                        state <= ST_IDLE;
                    end else if (FREE_RUN) begin
                        state     <= ST_START;
                        start_out <= 1'b1;
                        busy_out  <= 1'b1;
                        pose_out  <= pose_in;
                    end else begin
                        state <= ST_WAIT_SYNC;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of frame strobes that landed while a frame was in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            dropped_count_out <= '0;
        end else if (new_frame_in && in_frame && (dropped_count_out != DROP_MAX)) begin
            dropped_count_out <= dropped_count_out + 8'd1;
        end
    end

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Purpose: directed self-checking bench for render_frame_scheduler.
// Latency: n/a.
// Backpressure: n/a.
module tb_render_frame_scheduler;
    import render_sched_pkg::*;

    localparam int PW = 32;
    localparam int VW = POSE_COMPONENTS * PW;

    logic clk;
    logic rst_n;

    // Instance A: vsync locked, short watchdog.
    logic          en_a, nf_a;
    logic [1:0]    done_a;
    logic [VW-1:0] pose_a;
    logic          start_a, bsel_a, busy_a, tmo_a;
    logic [VW-1:0] posq_a;
    logic [15:0]   fcnt_a;
    logic [7:0]    drop_a;

    // Instance B: free running.
    logic          en_b, nf_b;
    logic [1:0]    done_b;
    logic [VW-1:0] pose_b;
    logic          start_b, bsel_b, busy_b, tmo_b;
    logic [VW-1:0] posq_b;
    logic [15:0]   fcnt_b;
    logic [7:0]    drop_b;

    int cyc;
    int n_checks;
    int n_fail;

    render_frame_scheduler #(
        .NUM_RENDERERS(2), .POSE_W(PW), .TIMEOUT_CYCLES(100), .VSYNC_LOCK(1)
    ) dut_lock (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en_a), .new_frame_in(nf_a),
        .done_in(done_a), .pose_in(pose_a), .start_out(start_a), .pose_out(posq_a),
        .buffer_sel_out(bsel_a), .busy_out(busy_a), .frame_count_out(fcnt_a),
        .dropped_count_out(drop_a), .timeout_out(tmo_a)
    );

    render_frame_scheduler #(
        .NUM_RENDERERS(2), .POSE_W(PW), .TIMEOUT_CYCLES(100), .VSYNC_LOCK(0)
    ) dut_free (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en_b), .new_frame_in(nf_b),
        .done_in(done_b), .pose_in(pose_b), .start_out(start_b), .pose_out(posq_b),
        .buffer_sel_out(bsel_b), .busy_out(busy_b), .frame_count_out(fcnt_b),
        .dropped_count_out(drop_b), .timeout_out(tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    function automatic logic [VW-1:0] mk_pose(input int seed);
        logic [VW-1:0] p;
        p = '0;
        for (int a = 0; a < 3; a++) begin
            p[pose_comp_lsb(POSE_IDX_ORI, a, PW) +: PW] = -32'(seed * 65536 + a + 1);
            p[pose_comp_lsb(POSE_IDX_FWD, a, PW) +: PW] = 32'(seed * 1000 + 10 + a);
            p[pose_comp_lsb(POSE_IDX_UP,  a, PW) +: PW] = 32'(seed * 1000 + 20 + a);
        end
        return p;
    endfunction

    initial begin
        logic [VW-1:0] p1;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n = 1'b0;
        en_a = 1'b0; nf_a = 1'b0; done_a = 2'b00; pose_a = '0;
        en_b = 1'b0; nf_b = 1'b0; done_b = 2'b00; pose_b = mk_pose(7);
        p1 = mk_pose(1);

        step();
        step();
        check("rst_start",  VW'(start_a), VW'(0));
        check("rst_pose",   posq_a,       VW'(0));
        check("rst_bsel",   VW'(bsel_a),  VW'(0));
        check("rst_busy",   VW'(busy_a),  VW'(0));
        check("rst_fcnt",   VW'(fcnt_a),  VW'(0));
        check("rst_drop",   VW'(drop_a),  VW'(0));
        check("rst_tmo",    VW'(tmo_a),   VW'(0));
        check("rst_b_busy", VW'(busy_b),  VW'(0));

        // ---- Frame 1: vsync start, pulse + level done, dropped strobes ----
        rst_n = 1'b1;
        cyc   = 0;
        en_a  = 1'b1;
        goto(10);
        nf_a   = 1'b1;
        pose_a = p1;
        step();                                   // cycle 11: START
        check("start_pulse", VW'(start_a), VW'(1));
        check("pose_latch",  posq_a,       p1);
        check("busy_start",  VW'(busy_a),  VW'(1));
        nf_a = 1'b0;
        step();                                   // cycle 12: RENDER
        check("start_one_cycle", VW'(start_a), VW'(0));
        check("busy_render",     VW'(busy_a),  VW'(1));
        while (cyc < 93) begin
            nf_a      = (cyc == 20) || (cyc == 25) || (cyc == 30);
            done_a[0] = (cyc == 61);
            done_a[1] = (cyc >= 91);
            pose_a    = mk_pose(cyc);
            step();
            if (cyc == 62) check("busy_after_pulse", VW'(busy_a), VW'(1));
            if (cyc == 91) check("busy_exit_cycle",  VW'(busy_a), VW'(1));
            if (cyc == 92) begin
                check("busy_swap", VW'(busy_a), VW'(0));
                check("bsel_swap", VW'(bsel_a), VW'(0));
            end
        end
        done_a = 2'b00;
        nf_a   = 1'b0;
        check("bsel_flip",   VW'(bsel_a), VW'(1));
        check("fcnt_one",    VW'(fcnt_a), VW'(1));
        check("pose_held",   posq_a,      p1);
        check("drop_three",  VW'(drop_a), VW'(3));
        check("tmo_clear",   VW'(tmo_a),  VW'(0));

        // ---- Frame 2: renderer 1 never finishes -> watchdog abort ----
        goto(95);
        nf_a = 1'b1;
        step();                                   // cycle 96: START
        nf_a = 1'b0;
        check("start_f2", VW'(start_a), VW'(1));
        goto(100);
        done_a = 2'b01;
        step();
        done_a = 2'b00;
        goto(196);
        check("busy_last_render", VW'(busy_a), VW'(1));
        check("tmo_not_yet",      VW'(tmo_a),  VW'(0));
        step();                                   // cycle 197
        check("tmo_set",       VW'(tmo_a),  VW'(1));
        check("busy_tmo",      VW'(busy_a), VW'(0));
        check("bsel_tmo_hold", VW'(bsel_a), VW'(1));
        check("fcnt_tmo_hold", VW'(fcnt_a), VW'(1));

        // ---- Next strobe restarts; held strobe saturates dropped count ----
        goto(200);
        nf_a = 1'b1;
        step();                                   // cycle 201: START
        check("start_after_tmo", VW'(start_a), VW'(1));
        check("tmo_sticky",      VW'(tmo_a),   VW'(1));
        goto(251);
        check("drop_53", VW'(drop_a), VW'(53));
        goto(501);
        nf_a = 1'b0;
        check("drop_sat", VW'(drop_a), VW'(255));

        // ---- Asynchronous reset mid-RENDER ----
        step();                                   // cycle 502: RENDER
        check("busy_pre_rst", VW'(busy_a), VW'(1));
        rst_n = 1'b0;
        #2;
        check("arst_start", VW'(start_a), VW'(0));
        check("arst_pose",  posq_a,       VW'(0));
        check("arst_bsel",  VW'(bsel_a),  VW'(0));
        check("arst_busy",  VW'(busy_a),  VW'(0));
        check("arst_fcnt",  VW'(fcnt_a),  VW'(0));
        check("arst_drop",  VW'(drop_a),  VW'(0));
        check("arst_tmo",   VW'(tmo_a),   VW'(0));
        step();
        step();

        // ---- Stale done level through START is discarded ----
        rst_n  = 1'b1;
        cyc    = 0;
        en_a   = 1'b1;
        done_a = 2'b11;
        goto(5);
        nf_a = 1'b1;
        step();                                   // cycle 6: START, done still high
        nf_a = 1'b0;
        check("start_stale", VW'(start_a), VW'(1));
        step();                                   // cycle 7: RENDER
        done_a = 2'b00;
        goto(10);
        check("stale_busy", VW'(busy_a), VW'(1));
        check("stale_fcnt", VW'(fcnt_a), VW'(0));
        goto(12);
        done_a = 2'b11;
        step();                                   // cycle 13: SWAP
        done_a = 2'b00;
        check("stale_swap_busy", VW'(busy_a), VW'(0));
        step();                                   // cycle 14
        check("stale_fcnt_one", VW'(fcnt_a), VW'(1));
        check("stale_bsel",     VW'(bsel_a), VW'(1));

        // ---- Free-run: starts every 8 cycles, enable drop completes frame ----
        goto(20);
        en_b = 1'b1;
        while (cyc < 50) begin
            done_b = ((cyc == 28) || (cyc == 36) || (cyc == 44)) ? 2'b11 : 2'b00;
            en_b   = (cyc < 40);
            step();
            check("free_start", VW'(start_b), VW'((cyc == 22) || (cyc == 30) || (cyc == 38)));
            if (cyc == 30) check("free_fcnt1",     VW'(fcnt_b), VW'(1));
            if (cyc == 38) check("free_fcnt2",     VW'(fcnt_b), VW'(2));
            if (cyc == 44) check("free_busy_exit", VW'(busy_b), VW'(1));
            if (cyc == 45) check("free_busy_swap", VW'(busy_b), VW'(0));
            if (cyc == 46) begin
                check("free_fcnt3", VW'(fcnt_b), VW'(3));
                check("free_bsel",  VW'(bsel_b), VW'(1));
                check("free_idle",  VW'(busy_b), VW'(0));
            end
        end
        check("free_pose", posq_b, mk_pose(7));
        check("free_drop", VW'(drop_b), VW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/render_frame_scheduler.md
# render_frame_scheduler

Sequences the parallel renderer instances (stereo pair by default) frame by frame. It gates each frame start on the video new-frame strobe and latches one camera pose for every renderer so both eyes render the same instant. It collects per-renderer done flags, toggles the display buffer select on completion and flags dropped or hung frames. It sits between `video_sig_gen`/pose source and the `renderer` instances, replacing the ad-hoc `start_next_frame` AND-gating.

## Interface
- `NUM_RENDERERS`, 2, number of renderer instances driven in lockstep
- `POSE_W`, 32, width of each signed Q16.16 pose component
- `TIMEOUT_CYCLES`, 2_000_000, max cycles in RENDER before abort (≥2)
- `VSYNC_LOCK`, 1, 1 = start only on `new_frame_in`; 0 = free-run (restart immediately after SWAP)

Ports:
- `clk_in`  in  1  renderer clock; all logic on rising edge
- `rst_in`  in  1  reset, asynchronous, active-low
- `enable_in`  in  1  run request; low parks in IDLE after current frame
- `new_frame_in`  in  1  one-cycle frame strobe, already synchronous to `clk_in`
- `done_in`  in  NUM_RENDERERS  per-renderer frame-done, pulse or level
- `pose_in`  in  9×POSE_W  {ori xyz, forward xyz, up xyz}, sampled continuously
- `start_out`  out  1  one-cycle start pulse to all renderers
- `pose_out`  out  9×POSE_W  pose held constant for the whole frame
- `buffer_sel_out`  out  1  display buffer index; renderers write the other one
- `busy_out`  out  1  high in START/RENDER
- `frame_count_out`  out  16  completed frames, wraps 0xFFFF→0
- `dropped_count_out`  out  8  strobes missed while busy, saturates at 255
- `timeout_out`  out  1  sticky: a frame was aborted

## Operation
- States: IDLE → WAIT_SYNC → START → RENDER → SWAP → (WAIT_SYNC | START | IDLE).
- IDLE: go to WAIT_SYNC when `enable_in`=1.
- WAIT_SYNC: with VSYNC_LOCK=1, go to START on `new_frame_in`. With VSYNC_LOCK=0, go to START next cycle. Go to IDLE if `enable_in`=0.
- START, one cycle: `start_out`=1, `pose_out`←`pose_in`, clear `done_seen`, clear watchdog. Go to RENDER.
- RENDER: `done_seen |= done_in` every cycle, so pulses are captured and levels are held. When `done_seen` is all ones, go to SWAP. If the watchdog reaches TIMEOUT_CYCLES−1 first, set `timeout_out` and go to WAIT_SYNC with no swap and no count.
- SWAP, one cycle: toggle `buffer_sel_out` and increment `frame_count_out`. Next state is IDLE if `enable_in`=0, else START if VSYNC_LOCK=0, else WAIT_SYNC.
- `new_frame_in` in START, RENDER or SWAP increments `dropped_count_out` (saturating) and is not queued.
- `done_in` is ignored outside RENDER. `done_in` high during the START cycle is discarded, because a stale level from the previous frame must not count.
- `enable_in` falling mid-frame does not abort; the frame completes first.

## Timing
- Reset values: state IDLE, `start_out` 0, `pose_out` 0, `buffer_sel_out` 0, `busy_out` 0, all counts 0, `timeout_out` 0.
- Reset assertion mid-frame returns to IDLE immediately and clears every output.
- All outputs are registered.
- `new_frame_in` in WAIT_SYNC at cycle n gives `start_out`=1 and new `pose_out` at n+1.
- If the last done bit is seen at cycle m, SWAP occurs at m+1. `buffer_sel_out` and `frame_count_out` update at m+2 (registered outputs of SWAP).
- A free-run frame has a 3-cycle overhead: START plus SWAP plus 1 detect cycle.
- `busy_out` is high from START through the RENDER exit cycle.
- Watchdog: 0 on START, +1 per RENDER cycle. If all done bits are set and the watchdog reaches TIMEOUT_CYCLES−1 in the same cycle, completion wins.

## Structure
- `render_sched_pkg`: state enum `sched_state_t`, `POSE_COMPONENTS`=9 constant, pose struct/index localparams.
- One natural sub-module, `render_watchdog`: a clear/enable/expire counter. The done collector, pose latch and counters stay inline.

## Test plan
- Reset, `enable_in`=1, VSYNC_LOCK=1, strobe at cycle 10 → `start_out` pulse at 11, `pose_out`=`pose_in`@10, `busy_out`=1.
- Renderer 0 pulses done at +50 and renderer 1 holds done level from +80 → SWAP once. `buffer_sel_out` 0→1 and `frame_count_out`=1; `pose_in` changes mid-frame do not affect `pose_out`.
- Three `new_frame_in` strobes during RENDER → `dropped_count_out`=3. With 300 strobes → saturates at 255.
- TIMEOUT_CYCLES=100, renderer 1 never done → `timeout_out`=1 after 100 RENDER cycles. `buffer_sel_out` and `frame_count_out` unchanged; next strobe starts a new frame.
- VSYNC_LOCK=0, done at RENDER+5 each frame → back-to-back starts every 8 cycles. `enable_in` dropped mid-frame → that frame completes, then IDLE with `busy_out`=0.
- Assert `rst_in` low mid-RENDER → all outputs reach reset values without waiting for a clock edge. Stale `done_in` high through START is not counted after restart.
